ft245_bus_sched: RTL and testbench
==================================

FT245_BUS_SCHED -- requirements
Module: ft245_bus_sched

Interface
REQ-001 Parameter BURST_MAX, default 256: maximum words per burst before the bus is re-arbitrated; legal range 1..65535.
REQ-002 Parameter TURNAROUND, default 2: idle cycles inserted after every burst; legal range 1..15.
REQ-003 usb_clk  in  1  the single clock; all state is on its rising edge.
REQ-004 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-005 usb_rxf  in  1  FT245 receive-data-available flag, active-low.
REQ-006 usb_txe  in  1  FT245 transmit-space-available flag, active-low.
REQ-007 tx_fifo_prog_empty  in  1  the TX FIFO (first-word-fall-through) holds too few words for a burst.
REQ-008 rx_fifo_prog_full  in  1  the RX FIFO is too full to accept a burst.
REQ-009 usb_oe_n, usb_rd_n, usb_wr_n  out  1 each  FT245 strobes, active-low, registered.
REQ-010 bus_drive  out  1  enables the FPGA drivers on usb_data/usb_be, registered.
REQ-011 tx_fifo_read  out  1  TX FIFO pop strobe.
REQ-012 rx_fifo_write  out  1  RX FIFO push strobe.
REQ-013 sched_state  out  3  current FSM state encoding, for debug.

Function
REQ-014 The FSM SHALL have five states: IDLE=0, RX_OE=1, RX_BURST=2, TX_BURST=3, TURN=4.
REQ-015 RX is eligible when usb_rxf=0 and rx_fifo_prog_full=0; TX is eligible when usb_txe=0 and tx_fifo_prog_empty=0.
REQ-016 In IDLE with exactly one direction eligible, the FSM SHALL go to RX_OE for RX or to TX_BURST for TX on the next edge.
REQ-017 In IDLE with both directions eligible, the FSM SHALL serve the direction opposite to the last served one (pref bit); pref SHALL reset to "RX first".
REQ-018 RX_OE: usb_oe_n=0 and usb_rd_n=1 for exactly one cycle, then RX_BURST.
REQ-019 RX_BURST: usb_oe_n=0 and usb_rd_n=0; rx_fifo_write SHALL equal (usb_rxf=0) in that cycle, combinationally.
REQ-020 TX_BURST: bus_drive=1 and usb_wr_n=0; tx_fifo_read SHALL equal (usb_txe=0) in that cycle, combinationally.
REQ-021 A 16-bit burst counter SHALL clear on burst entry and increment on each transfer cycle.
REQ-022 A burst SHALL exit to TURN on the edge after any of the following: a transfer with counter=BURST_MAX-1; the device flag going high; rx_fifo_prog_full=1 (RX) or tx_fifo_prog_empty=1 (TX).
REQ-023 On a burst exit, pref SHALL be set to the opposite of the direction just served.
REQ-024 TURN: all strobes high and bus_drive=0 for exactly TURNAROUND cycles, then IDLE.
REQ-025 bus_drive=1 and usb_oe_n=0 SHALL never be true in the same cycle.
REQ-026 With neither direction eligible, the FSM SHALL hold IDLE indefinitely with all strobes inactive.

Reset
REQ-027 Whenever rst_n=0, outputs SHALL be forced immediately: usb_oe_n=usb_rd_n=usb_wr_n=1, bus_drive=0, tx_fifo_read=rx_fifo_write=0, sched_state=IDLE, counter=0, pref=RX.
REQ-028 A reset asserted mid-burst SHALL abort the burst with no further strobe; the first arbitration SHALL occur on the first edge after rst_n rises.

Configuration
REQ-029 With FT245_SCHED_STATS_EN defined, the block SHALL add 32-bit outputs tx_word_cnt and rx_word_cnt, incremented per transfer, wrapping at 2^32, cleared by reset.
REQ-030 Without FT245_SCHED_STATS_EN, those ports and counters SHALL be absent and all other behaviour SHALL be unchanged.

Verification
REQ-031 Only RX is eligible, usb_rxf held low, BURST_MAX=4: RX_OE for 1 cycle, then 4 rx_fifo_write pulses, then TURN for 2 cycles, then IDLE.
REQ-032 Both directions permanently eligible, BURST_MAX=4: bursts alternate RX, TX, RX, TX, each 4 words long and separated by 2 TURN cycles.
REQ-033 TX burst with usb_txe raised after 3 words: exactly 3 tx_fifo_read pulses, then TURN on the next edge, with bus_drive=0 during TURN.
REQ-034 rx_fifo_prog_full asserted during RX_BURST word 2: the burst exits on the next edge; no rx_fifo_write occurs after exit.
REQ-035 rst_n pulsed low in the middle of TX_BURST: bus_drive drops and usb_wr_n rises in the same cycle, and sched_state=0.
REQ-036 With stats enabled, 10 TX words and 7 RX words transferred: tx_word_cnt=10 and rx_word_cnt=7.

Source files
------------

// File: rtl/ft245_bus_sched_if.sv
// Bus bundle between the FT245 scheduler and its environment (FT245 flags/strobes, FIFO levels/strobes).
// Optional FT245_SCHED_STATS_EN adds the per-direction word counters.
interface ft245_bus_sched_if;
    logic        usb_rxf;
    logic        usb_txe;
    logic        tx_fifo_prog_empty;
    logic        rx_fifo_prog_full;
    logic        usb_oe_n;
    logic        usb_rd_n;
    logic        usb_wr_n;
    logic        bus_drive;
    logic        tx_fifo_read;
    logic        rx_fifo_write;
    logic [2:0]  sched_state;
`ifdef FT245_SCHED_STATS_EN
    logic [31:0] tx_word_cnt;
    logic [31:0] rx_word_cnt;
`endif

    modport master (
        input  usb_rxf, usb_txe, tx_fifo_prog_empty, rx_fifo_prog_full,
        output usb_oe_n, usb_rd_n, usb_wr_n, bus_drive,
        output tx_fifo_read, rx_fifo_write, sched_state
`ifdef FT245_SCHED_STATS_EN
        , output tx_word_cnt, rx_word_cnt
`endif
    );

    modport slave (
        output usb_rxf, usb_txe, tx_fifo_prog_empty, rx_fifo_prog_full,
        input  usb_oe_n, usb_rd_n, usb_wr_n, bus_drive,
        input  tx_fifo_read, rx_fifo_write, sched_state
`ifdef FT245_SCHED_STATS_EN
        , input tx_word_cnt, rx_word_cnt
`endif
    );
endinterface

// File: rtl/ft245_bus_sched.sv
// FT245 half-duplex bus scheduler: alternating RX/TX bursts of up to BURST_MAX words, TURNAROUND idle cycles between.
// Latency: arbitration one edge after eligibility; RX adds one OE cycle. Backpressure: FIFO prog flags / device flags end bursts.
// Optional macro FT245_SCHED_STATS_EN adds 32-bit tx_word_cnt/rx_word_cnt outputs.
module ft245_bus_sched #(
    parameter int unsigned BURST_MAX  = 256,
    parameter int unsigned TURNAROUND = 2
) (
    input  logic              usb_clk,
    input  logic              rst_n,
    ft245_bus_sched_if.master bus
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        RX_OE    = 3'd1,
        RX_BURST = 3'd2,
        TX_BURST = 3'd3,
        TURN     = 3'd4
    } state_t;

    localparam logic [15:0] LAST_WORD = 16'(BURST_MAX - 1);
    localparam logic [3:0]  TURN_LAST = 4'(TURNAROUND - 1);

    state_t      state;
    logic [15:0] burst_cnt;
    logic [3:0]  turn_cnt;
    logic        pref_tx;
    logic        oe_n_q;
    logic        rd_n_q;
    logic        wr_n_q;
    logic        drive_q;

    logic rx_ok;
    logic tx_ok;
    logic rx_xfer;
    logic tx_xfer;
    logic rx_stop;
    logic tx_stop;

    assign rx_ok   = !bus.usb_rxf && !bus.rx_fifo_prog_full;
    assign tx_ok   = !bus.usb_txe && !bus.tx_fifo_prog_empty;
    assign rx_xfer = (state == RX_BURST) && !bus.usb_rxf;
    assign tx_xfer = (state == TX_BURST) && !bus.usb_txe;
    assign rx_stop = (rx_xfer && (burst_cnt == LAST_WORD)) || bus.usb_rxf || bus.rx_fifo_prog_full;
    assign tx_stop = (tx_xfer && (burst_cnt == LAST_WORD)) || bus.usb_txe || bus.tx_fifo_prog_empty;

    // Strobes are computed together with the next state so they line up with sched_state.
    always_ff @(posedge usb_clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            burst_cnt <= 16'd0;
            turn_cnt  <= 4'd0;
            pref_tx   <= 1'b0;
            oe_n_q    <= 1'b1;
            rd_n_q    <= 1'b1;
            wr_n_q    <= 1'b1;
            drive_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (rx_ok && (!tx_ok || !pref_tx)) begin
                        state     <= RX_OE;
                        oe_n_q    <= 1'b0;
                        burst_cnt <= 16'd0;
                    end else if (tx_ok) begin
                        state     <= TX_BURST;
                        wr_n_q    <= 1'b0;
                        drive_q   <= 1'b1;
                        burst_cnt <= 16'd0;
                    end
                end
                RX_OE: begin
                    state     <= RX_BURST;
                    rd_n_q    <= 1'b0;
                    burst_cnt <= 16'd0;
                end
                RX_BURST: begin
                    if (rx_xfer) begin
                        burst_cnt <= burst_cnt + 16'd1;
                    end
                    if (rx_stop) begin
                        state    <= TURN;
                        oe_n_q   <= 1'b1;
                        rd_n_q   <= 1'b1;
                        turn_cnt <= TURN_LAST;
                        pref_tx  <= 1'b1;
                    end
                end
                TX_BURST: begin
                    if (tx_xfer) begin
                        burst_cnt <= burst_cnt + 16'd1;
                    end
                    if (tx_stop) begin
                        state    <= TURN;
                        wr_n_q   <= 1'b1;
                        drive_q  <= 1'b0;
                        turn_cnt <= TURN_LAST;
                        pref_tx  <= 1'b0;
                    end
                end
                TURN: begin
                    if (turn_cnt == 4'd0) begin
                        state <= IDLE;
                    end else begin
                        turn_cnt <= turn_cnt - 4'd1;
                    end
                end
                default: begin
                    state   <= IDLE;
                    oe_n_q  <= 1'b1;
                    rd_n_q  <= 1'b1;
                    wr_n_q  <= 1'b1;
                    drive_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.usb_oe_n      = oe_n_q;
    assign bus.usb_rd_n      = rd_n_q;
    assign bus.usb_wr_n      = wr_n_q;
    assign bus.bus_drive     = drive_q;
    assign bus.rx_fifo_write = rx_xfer;
    assign bus.tx_fifo_read  = tx_xfer;
    assign bus.sched_state   = state;

`ifdef FT245_SCHED_STATS_EN
    logic [31:0] tx_words;
    logic [31:0] rx_words;

    always_ff @(posedge usb_clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_words <= 32'd0;
            rx_words <= 32'd0;
        end else begin
            if (tx_xfer) begin
                tx_words <= tx_words + 32'd1;
            end
            if (rx_xfer) begin
                rx_words <= rx_words + 32'd1;
            end
        end
    end

    assign bus.tx_word_cnt = tx_words;
    assign bus.rx_word_cnt = rx_words;
`endif

endmodule

// File: tb/tb_ft245_bus_sched.sv
// Scoreboard bench for ft245_bus_sched: stimulus pushes expected per-cycle outputs from a burst-level model,
// a negedge monitor pops and compares.
module tb_ft245_bus_sched;

    localparam int BMAX = 4;
    localparam int TA   = 2;

    logic usb_clk = 1'b0;
    logic rst_n   = 1'b0;
    always #5 usb_clk = ~usb_clk;

    ft245_bus_sched_if bus ();

    ft245_bus_sched #(
        .BURST_MAX (BMAX),
        .TURNAROUND(TA)
    ) dut (
        .usb_clk(usb_clk),
        .rst_n  (rst_n),
        .bus    (bus)
    );

    typedef logic [8:0] obs_t;   // {state[2:0], oe_n, rd_n, wr_n, drive, tx_read, rx_write}
    obs_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Burst-level reference model
    int          gap_left;   // turnaround cycles still owed
    bit          opening;    // RX output-enable lead-in cycle pending
    int          serving;    // 0 none, 1 rx, 2 tx
    int          words;      // words moved in the current burst
    bit          tx_next;    // TX wins a tie
    int unsigned rx_total;
    int unsigned tx_total;

    function automatic void model_reset();
        gap_left = 0;
        opening  = 1'b0;
        serving  = 0;
        words    = 0;
        tx_next  = 1'b0;
        rx_total = 0;
        tx_total = 0;
    endfunction

    function automatic obs_t observe();
        return {bus.sched_state, bus.usb_oe_n, bus.usb_rd_n, bus.usb_wr_n,
                bus.bus_drive, bus.tx_fifo_read, bus.rx_fifo_write};
    endfunction

    task automatic step(input bit rxf, input bit txe, input bit pe, input bit pf, input bit rst);
        obs_t e;
        int   code;
        bit   xfer;
        bit   rx_ok;
        bit   tx_ok;
        @(posedge usb_clk);
        #1;
        bus.usb_rxf            = rxf;
        bus.usb_txe            = txe;
        bus.tx_fifo_prog_empty = pe;
        bus.rx_fifo_prog_full  = pf;
        rst_n                  = rst;
        if (!rst) begin
            model_reset();
            e = 9'b000_1110_00;
        end else begin
            code = (gap_left > 0) ? 4 : opening ? 1 : (serving == 1) ? 2 : (serving == 2) ? 3 : 0;
            e = {3'(code), !(opening || serving == 1), !(serving == 1), !(serving == 2),
                 serving == 2, (serving == 2) && !txe, (serving == 1) && !rxf};
            if (serving == 1 && !rxf) rx_total++;
            if (serving == 2 && !txe) tx_total++;
            if (gap_left > 0) begin
                gap_left--;
            end else if (opening) begin
                opening = 1'b0;
                serving = 1;
                words   = 0;
            end else if (serving == 1) begin
                xfer = !rxf;
                if (xfer) words++;
                if ((xfer && words == BMAX) || rxf || pf) begin
                    serving  = 0;
                    gap_left = TA;
                    tx_next  = 1'b1;
                end
            end else if (serving == 2) begin
                xfer = !txe;
                if (xfer) words++;
                if ((xfer && words == BMAX) || txe || pe) begin
                    serving  = 0;
                    gap_left = TA;
                    tx_next  = 1'b0;
                end
            end else begin
                rx_ok = !rxf && !pf;
                tx_ok = !txe && !pe;
                if (rx_ok && (!tx_ok || !tx_next)) begin
                    opening = 1'b1;
                end else if (tx_ok) begin
                    serving = 2;
                    words   = 0;
                end
            end
        end
        exp_q.push_back(e);
    endtask

    initial begin : monitor
        obs_t e;
        obs_t got;
        forever begin
            @(negedge usb_clk);
            if (exp_q.size() > 0) begin
                e   = exp_q.pop_front();
                got = observe();
                n_checks++;
                if (got !== e) begin
                    n_fail++;
                    $display("FAIL cycle_outputs t=%0t got=%b expected=%b (state,oe_n,rd_n,wr_n,drive,txrd,rxwr)",
                             $time, got, e);
                end
                n_checks++;
                if (bus.bus_drive === 1'b1 && bus.usb_oe_n === 1'b0) begin
                    n_fail++;
                    $display("FAIL drive_oe_overlap t=%0t bus_drive=%b usb_oe_n=%b expected not both active",
                             $time, bus.bus_drive, bus.usb_oe_n);
                end
            end
        end
    end

    initial begin : stimulus
        bit done;
        int guard;
        model_reset();
        bus.usb_rxf            = 1'b1;
        bus.usb_txe            = 1'b1;
        bus.tx_fifo_prog_empty = 1'b1;
        bus.rx_fifo_prog_full  = 1'b0;

        for (int i = 0; i < 3; i++) step(1, 1, 1, 0, 0);
        // Nothing eligible: parked in IDLE
        for (int i = 0; i < 10; i++) step(1, 1, 0, 0, 1);
        // RX only, flag held low
        for (int i = 0; i < 30; i++) step(0, 1, 0, 0, 1);
        // Both permanently eligible: strict alternation
        for (int i = 0; i < 60; i++) step(0, 0, 0, 0, 1);
        // TX only, device flag rises after 3 words
        for (int i = 0; i < 40; i++) step(1, (serving == 2 && words >= 3), 0, 0, 1);
        // RX only, FIFO almost-full during word 2
        for (int i = 0; i < 40; i++) step(0, 1, 0, (serving == 1 && words == 1), 1);
        // Reset in the middle of a TX burst
        done = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (!done && serving == 2 && words == 2) begin
                done = 1'b1;
                step(0, 0, 0, 0, 0);
            end else begin
                step(0, 0, 0, 0, 1);
            end
        end
        // Randomized traffic with occasional resets
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
                 $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0,
                 $urandom_range(0, 399) != 0);
        end
        for (int i = 0; i < 8; i++) step(1, 1, 0, 0, 1);

        guard = 0;
        while (exp_q.size() > 0 && guard < 20) begin
            @(negedge usb_clk);
            guard++;
        end
        @(negedge usb_clk);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain left=%0d expected=0", exp_q.size());
        end

`ifdef FT245_SCHED_STATS_EN
        n_checks++;
        if (bus.tx_word_cnt !== tx_total) begin
            n_fail++;
            $display("FAIL tx_word_cnt got=%0d expected=%0d", bus.tx_word_cnt, tx_total);
        end
        n_checks++;
        if (bus.rx_word_cnt !== rx_total) begin
            n_fail++;
            $display("FAIL rx_word_cnt got=%0d expected=%0d", bus.rx_word_cnt, rx_total);
        end
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
